// File: rtl/calc_op_sched.sv
// calc_op_sched: operation scheduler for the calculator datapath.
// Evaluates add/sub locally, dispatches mul/div to shared sequential units
// over Go/Done handshakes, traps divide-by-zero before launching the divider,
// and aborts a unit that never answers after TIMEOUT wait cycles.
//
// Ports:
//   CLK, rst            clock (rising edge), synchronous active-high reset
//   Go, op, A, B        request strobe (sampled in IDLE), opcode, operands
//   busy                high whenever the scheduler is not idle
//   unit_x, unit_y      shared operand buses, driven from the latched operands
//   mul_go/mul_done/mul_p          multiplier handshake and product
//   div_go/div_done/div_q/div_r    divider handshake, quotient and remainder
//   result, rem         registered result and remainder (rem is 0 unless div)
//   Done                one-cycle completion pulse
//   Error, timeout      sticky divide-by-zero and watchdog flags
module calc_op_sched #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 Go,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic [WIDTH-1:0]     unit_x,
  output logic [WIDTH-1:0]     unit_y,
  output logic                 mul_go,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic                 div_go,
  input  logic                 div_done,
  input  logic [WIDTH-1:0]     div_q,
  input  logic [WIDTH-1:0]     div_r,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     rem,
  output logic                 Done,
  output logic                 Error,
  output logic                 timeout
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;
  logic                 sel_done;

  // Only the unit that was launched may complete the operation.
  assign sel_done = (op_q == OP_DIV) ? div_done : mul_done;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    timer_d   = timer_q;
    result_d  = result_q;
    rem_d     = rem_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (Go) begin
          a_d       = A;
          b_d       = B;
          op_d      = op_t'(op);
          error_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (op_q)
          OP_ADD: begin
            result_d = (2*WIDTH)'(a_q) + (2*WIDTH)'(b_q);
            rem_d    = '0;
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = (2*WIDTH)'(a_q) - (2*WIDTH)'(b_q);
            rem_d    = '0;
            state_d  = S_DONE;
          end
          OP_DIV: begin
            if (b_q == '0) begin
              error_d  = 1'b1;
              result_d = '0;
              rem_d    = '0;
              state_d  = S_DONE;
            end else begin
              state_d  = S_LAUNCH;
            end
          end
          default: state_d = S_LAUNCH;
        endcase
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion beats the watchdog when both land on the same cycle.
        if (sel_done) begin
          if (op_q == OP_DIV) begin
            result_d = (2*WIDTH)'(div_q);
            rem_d    = div_r;
          end else begin
            result_d = mul_p;
            rem_d    = '0;
          end
          state_d = S_DONE;
        end else if (timer_q == TIMER_MAX) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      timer_q   <= '0;
      result_q  <= '0;
      rem_q     <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      timer_q   <= timer_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore outputs decoded from the state and result registers.
  assign busy    = (state_q != S_IDLE);
  assign mul_go  = (state_q == S_LAUNCH) && (op_q == OP_MUL);
  assign div_go  = (state_q == S_LAUNCH) && (op_q == OP_DIV);
  assign Done    = (state_q == S_DONE);
  assign unit_x  = a_q;
  assign unit_y  = b_q;
  assign result  = result_q;
  assign rem     = rem_q;
  assign Error   = error_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_calc_op_sched.sv
// Testbench for calc_op_sched (WIDTH=4, TIMEOUT=64). Expected completion
// records {result, rem, Error, timeout} are queued when a request is issued
// and compared when Done pulses. Unit responses are driven by the tasks.
module tb_calc_op_sched;

  logic       CLK;
  logic       rst;
  logic       Go;
  logic [1:0] op;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic [3:0] unit_x;
  logic [3:0] unit_y;
  logic       mul_go;
  logic       mul_done;
  logic [7:0] mul_p;
  logic       div_go;
  logic       div_done;
  logic [3:0] div_q;
  logic [3:0] div_r;
  logic [7:0] result;
  logic [3:0] rem;
  logic       Done;
  logic       Error;
  logic       timeout;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] rem;
    logic       err;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  exp_t obs;
  exp_t expv;
  int   errors = 0;
  int   checks = 0;

  calc_op_sched #(.WIDTH(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .rst(rst), .Go(Go), .op(op), .A(A), .B(B),
    .busy(busy), .unit_x(unit_x), .unit_y(unit_y),
    .mul_go(mul_go), .mul_done(mul_done), .mul_p(mul_p),
    .div_go(div_go), .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .result(result), .rem(rem), .Done(Done), .Error(Error), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // An empty queue yields an all-ones record, which no legal completion matches.
  function automatic exp_t pop_exp();
    if (sb.size() == 0) return '1;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    rst = 1'b1; Go = 1'b0; op = 2'b00; A = '0; B = '0;
    mul_done = 1'b0; mul_p = '0; div_done = 1'b0; div_q = '0; div_r = '0;
    tick(); tick();
    checks++;
    if ({busy, mul_go, div_go, Done, Error, timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {busy, mul_go, div_go, Done, Error, timeout});
    end
    checks++;
    if ({result, rem, unit_x, unit_y} !== 20'h0) begin
      errors++; $display("FAIL reset_data: got %h want 00000", {result, rem, unit_x, unit_y});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    Go = 1'b1; op = 2'b00; A = 4'd9; B = 4'd8;
    sb.push_back({8'h11, 4'h0, 1'b0, 1'b0});
    tick(); Go = 1'b0;
    checks++;
    if (Done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL add_decode: Done=%b busy=%b want 0 1", Done, busy);
    end
    tick();
    checks++;
    if (Done !== 1'b1 || mul_go !== 1'b0 || div_go !== 1'b0) begin
      errors++; $display("FAIL add_latency: Done=%b mul_go=%b div_go=%b want 1 0 0", Done, mul_go, div_go);
    end
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL add_result: got %h want %h", obs, expv);
    end
    tick();
  endtask

  task automatic test_sub();
    int busy_cnt = 0;
    int done_cnt = 0;
    Go = 1'b1; op = 2'b01; A = 4'd3; B = 4'd5;
    sb.push_back({8'hFE, 4'h0, 1'b0, 1'b0});
    tick(); Go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (Done === 1'b1) begin
        done_cnt++;
        obs = {result, rem, Error, timeout}; expv = pop_exp();
        checks++;
        if (obs !== expv) begin
          errors++; $display("FAIL sub_result: got %h want %h", obs, expv);
        end
      end
      tick();
    end
    checks++;
    if (busy_cnt != 2 || done_cnt != 1) begin
      errors++; $display("FAIL sub_pulses: busy=%0d done=%0d want 2 1", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_div();
    Go = 1'b1; op = 2'b11; A = 4'd13; B = 4'd4;
    sb.push_back({8'h03, 4'h1, 1'b0, 1'b0});
    tick(); Go = 1'b0;
    tick();
    checks++;
    if (div_go !== 1'b1 || mul_go !== 1'b0) begin
      errors++; $display("FAIL div_launch: div_go=%b mul_go=%b want 1 0", div_go, mul_go);
    end
    tick();
    checks++;
    if (div_go !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL div_wait: div_go=%b Done=%b want 0 0", div_go, Done);
    end
    div_done = 1'b1; div_q = 4'd3; div_r = 4'd1;
    tick();
    div_done = 1'b0; div_q = '0; div_r = '0;
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("FAIL div_done: Done=%b want 1", Done);
    end
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL div_result: got %h want %h", obs, expv);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int go_seen = 0;
    Go = 1'b1; op = 2'b11; A = 4'd7; B = 4'd0;
    sb.push_back({8'h00, 4'h0, 1'b1, 1'b0});
    tick(); Go = 1'b0;
    if (div_go === 1'b1) go_seen++;
    tick();
    if (div_go === 1'b1) go_seen++;
    checks++;
    if (Done !== 1'b1 || go_seen != 0) begin
      errors++; $display("FAIL div0_latency: Done=%b div_go_cycles=%0d want 1 0", Done, go_seen);
    end
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL div0_result: got %h want %h", obs, expv);
    end
    tick(); tick();
    checks++;
    if (Error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL div0_sticky: Error=%b busy=%b want 1 0", Error, busy);
    end
  endtask

  task automatic test_mul();
    Go = 1'b1; op = 2'b10; A = 4'd15; B = 4'd15;
    sb.push_back({8'hE1, 4'h0, 1'b0, 1'b0});
    tick(); Go = 1'b0; A = 4'd1; B = 4'd2;
    checks++;
    if (unit_x !== 4'd15 || unit_y !== 4'd15 || mul_go !== 1'b0 || Error !== 1'b0) begin
      errors++; $display("FAIL mul_decode: x=%0d y=%0d mul_go=%b Error=%b want 15 15 0 0", unit_x, unit_y, mul_go, Error);
    end
    tick();
    checks++;
    if (mul_go !== 1'b1 || div_go !== 1'b0) begin
      errors++; $display("FAIL mul_launch: mul_go=%b div_go=%b want 1 0", mul_go, div_go);
    end
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (mul_go !== 1'b0 || div_go !== 1'b0 || Done !== 1'b0 || unit_x !== 4'd15 || unit_y !== 4'd15) begin
        errors++; $display("FAIL mul_wait%0d: mul_go=%b div_go=%b Done=%b x=%0d y=%0d want 0 0 0 15 15", i, mul_go, div_go, Done, unit_x, unit_y);
      end
      div_done = (i == 3);
      div_q    = (i == 3) ? 4'hF : 4'h0;
      if (i == 6) begin
        mul_done = 1'b1; mul_p = 8'hE1;
      end
    end
    tick();
    mul_done = 1'b0; mul_p = '0;
    checks++;
    if (Done !== 1'b1 || unit_x !== 4'd15 || unit_y !== 4'd15) begin
      errors++; $display("FAIL mul_done: Done=%b x=%0d y=%0d want 1 15 15", Done, unit_x, unit_y);
    end
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL mul_result: got %h want %h", obs, expv);
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    Go = 1'b1; op = 2'b10; A = 4'd2; B = 4'd3;
    sb.push_back({8'hE1, 4'h0, 1'b0, 1'b1});
    tick(); Go = 1'b0;
    tick();
    for (int i = 0; i < 200; i++) begin
      tick();
      cnt++;
      if (Done === 1'b1) break;
    end
    checks++;
    if (Done !== 1'b1 || cnt != 65) begin
      errors++; $display("FAIL tmo_latency: Done=%b cycles=%0d want 1 65", Done, cnt);
    end
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (obs !== expv) begin
      errors++; $display("FAIL tmo_result: got %h want %h", obs, expv);
    end
    tick(); tick();
    checks++;
    if (timeout !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: timeout=%b want 1", timeout);
    end
    Go = 1'b1; op = 2'b00; A = 4'd1; B = 4'd1;
    sb.push_back({8'h02, 4'h0, 1'b0, 1'b0});
    tick(); Go = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL tmo_clear: timeout=%b want 0", timeout);
    end
    tick();
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (Done !== 1'b1 || obs !== expv) begin
      errors++; $display("FAIL tmo_next: Done=%b got %h want 1 %h", Done, obs, expv);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    Go = 1'b1; op = 2'b00; A = 4'd4; B = 4'd5;
    sb.push_back({8'h09, 4'h0, 1'b0, 1'b0});
    tick();
    op = 2'b01; A = 4'd6; B = 4'd2;
    tick();
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (Done !== 1'b1 || obs !== expv) begin
      errors++; $display("FAIL b2b_first: Done=%b got %h want 1 %h", Done, obs, expv);
    end
    sb.push_back({8'h04, 4'h0, 1'b0, 1'b0});
    tick();
    checks++;
    if (busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b Done=%b want 0 0", busy, Done);
    end
    tick(); Go = 1'b0;
    checks++;
    if (busy !== 1'b1 || unit_x !== 4'd6 || unit_y !== 4'd2) begin
      errors++; $display("FAIL b2b_accept: busy=%b x=%0d y=%0d want 1 6 2", busy, unit_x, unit_y);
    end
    tick();
    obs = {result, rem, Error, timeout}; expv = pop_exp();
    checks++;
    if (Done !== 1'b1 || obs !== expv) begin
      errors++; $display("FAIL b2b_second: Done=%b got %h want 1 %h", Done, obs, expv);
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    Go = 1'b1; op = 2'b11; A = 4'd9; B = 4'd3;
    tick(); Go = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL rstw_pre: busy=%b Done=%b want 1 0", busy, Done);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, mul_go, div_go, Done, Error, timeout} !== 6'b0 || {result, rem, unit_x, unit_y} !== 20'h0) begin
      errors++; $display("FAIL rstw_state: ctrl=%b data=%h want 000000 00000", {busy, mul_go, div_go, Done, Error, timeout}, {result, rem, unit_x, unit_y});
    end
    div_done = 1'b1; div_q = 4'd3; div_r = 4'd0;
    tick();
    div_done = 1'b0; div_q = '0;
    tick();
    checks++;
    if (busy !== 1'b0 || Done !== 1'b0 || div_go !== 1'b0 || result !== 8'h00) begin
      errors++; $display("FAIL rstw_after: busy=%b Done=%b div_go=%b result=%h want 0 0 0 00", busy, Done, div_go, result);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_empty: pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_div();
    test_div_zero();
    test_mul();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_op_sched.md
Name: calc_op_sched

Overview:
- Top-level operation scheduler for the calculator datapath.
- Accepts one operation request (add, sub, mul, div) and evaluates add/sub locally.
- Dispatches mul/div to the shared sequential multiplier and divider units via their Go/Done handshakes, then captures the result.
- Catches divide-by-zero before launching the divider; a watchdog timer aborts a hung unit.

Parameters:
- WIDTH, 4, operand width in bits.
- TIMEOUT, 64, max WAIT cycles before abort (must be >= 2).

Ports:
- CLK  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- Go  in  1  request strobe; sampled only in IDLE.
- op  in  2  00 add, 01 sub, 10 mul, 11 div.
- A  in  WIDTH  operand X / dividend.
- B  in  WIDTH  operand Y / divisor.
- busy  out  1  high whenever state != IDLE.
- unit_x  out  WIDTH  shared operand bus X, driven from latched A.
- unit_y  out  WIDTH  shared operand bus Y, driven from latched B.
- mul_go  out  1  multiplier start pulse.
- mul_done  in  1  multiplier completion.
- mul_p  in  2*WIDTH  multiplier product.
- div_go  out  1  divider start pulse.
- div_done  in  1  divider completion.
- div_q  in  WIDTH  quotient.
- div_r  in  WIDTH  remainder.
- result  out  2*WIDTH  registered result.
- rem  out  WIDTH  registered remainder; 0 for non-div ops.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  sticky divide-by-zero flag.
- timeout  out  1  sticky watchdog flag.

Behaviour:

Reset (sync; rst has priority over all other inputs):
- State goes to IDLE.
- result, rem, latched A/B/op and the timer clear to 0.
- Error and timeout clear to 0.
- busy, mul_go, div_go and Done are 0 in the cycle after the reset edge.
- Reset mid-WAIT abandons the unit; no go pulse is reissued.

States: IDLE, DECODE, LAUNCH, WAIT, DONE. All outputs are Moore-decoded from state and registers.
- IDLE:
  - On Go=1: latch A, B, op; clear Error and timeout; go to DECODE.
  - Go while busy is ignored (no queueing).
- DECODE:
  - add: result <= zero-extended A+B (carry lands in bit WIDTH); rem <= 0; go to DONE.
  - sub: result <= (A-B) mod 2^(2*WIDTH), i.e. the two's-complement 2*WIDTH-bit difference; rem <= 0; go to DONE.
  - div with B==0: Error <= 1; result <= 0; rem <= 0; go to DONE; divider is not launched.
  - mul, or div with B!=0: go to LAUNCH.
- LAUNCH:
  - mul_go=1 (op mul) or div_go=1 (op div) for exactly this cycle.
  - Timer clears to 0; go to WAIT.
- WAIT, evaluated in priority order:
  - Selected unit's done=1: capture result (mul: mul_p; div: {0, div_q}, rem <= div_r); go to DONE.
  - Else if timer == TIMEOUT-1: timeout <= 1; result and rem are left unchanged; go to DONE.
  - Else: timer increments.
  - The non-selected unit's done is ignored.
  - If done and the timer limit coincide, done wins.
- DONE: Done=1 for one cycle; go to IDLE.

Bus and output timing:
- unit_x and unit_y are stable from DECODE through DONE.
- result, rem, Error and timeout hold until the next accepted Go or reset.

Latency (Go sampled at edge 0):
- add/sub/div-by-zero: Done is high in the cycle after edge 1.
- mul/div: go pulse follows edge 1; Done is high one cycle after the edge that samples unit done.

Test Plan:
- WIDTH=4, add A=9, B=8: Done is high 2 cycles after Go; result=0x11, rem=0; Error=0; no go pulse.
- sub A=3, B=5: result=0xFE; Done is a single-cycle pulse; busy is high for exactly 2 cycles.
- mul A=15, B=15, model returns done 6 cycles after mul_go: mul_go is 1 cycle; result=0xE1; div_go stays 0; unit_x=15 and unit_y=15 hold throughout.
- div A=13, B=4: div_go pulse; result=0x03, rem=1. Div with B=0: Error=1, result=0, no div_go, Done 2 cycles after Go.
- Model never asserts done, TIMEOUT=64: timeout=1 and Done after 64 WAIT cycles; the next accepted Go clears timeout. Stray div_done during a mul is ignored.
- rst asserted in WAIT: next cycle state=IDLE, all outputs 0. Go held high while busy does not start a second op; Go held through DONE starts a new op from IDLE.
